alu_cmd_issuer: RTL and testbench

- Upstream command stage for the ALU. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU using its start/done protocol, and returns each result on a valid/ready response port in command order.
- Completes no-op commands locally without using the ALU.
- A watchdog flags an ALU that never asserts done.

---
 rtl/alu_cmd_issuer.sv | 169 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command front-end for the ALU: queues operand/opcode commands, runs them one at a
// time through the ALU start/done handshake, and returns results in order.
module alu_cmd_issuer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  input  logic [OP_W-1:0]          cmd_op,
  output logic                     alu_start,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic                     alu_done,
  input  logic [2*DATA_W-1:0]      alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*DATA_W-1:0]      rsp_result,
  output logic [OP_W-1:0]          rsp_op,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int RES_W = 2 * DATA_W;
  localparam int ENT_W = OP_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop, rsp_free;
  logic [OP_W-1:0]   head_op;
  logic [DATA_W-1:0] head_a, head_b;

  logic [WD_W-1:0]   wd;
  logic              issue, load_rsp, load_err;
  logic [RES_W-1:0]  load_res;
  logic [OP_W-1:0]   load_op;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && cmd_ready;
  assign rsp_free   = !rsp_valid || rsp_ready;
  assign fifo_count = count;
  assign {head_op, head_a, head_b} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ALU completion and timeout load the response on the exiting edge so done->rsp_valid
  // is one cycle; only no-ops pass through the RESP state.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    issue      = 1'b0;
    load_rsp   = 1'b0;
    load_res   = '0;
    load_op    = '0;
    load_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && rsp_free) begin
          pop = 1'b1;
          if (head_op == '0) begin
            state_next = S_RESP;
          end else begin
            issue      = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          load_rsp   = 1'b1;
          load_res   = alu_result;
          load_op    = alu_opcode;
          state_next = S_IDLE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          load_rsp   = 1'b1;
          load_op    = alu_opcode;
          load_err   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RESP: begin
        load_rsp   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_start  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      wd         <= '0;
    end else begin
      if (issue) begin
        alu_start  <= 1'b1;
        alu_opcode <= head_op;
        alu_a      <= head_a;
        alu_b      <= head_b;
        wd         <= '0;
      end else if (state == S_WAIT) begin
        wd <= wd + WD_W'(1);
        if (load_rsp) alu_start <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else if (load_rsp) begin
      rsp_valid  <= 1'b1;
      rsp_result <= load_res;
      rsp_op     <= load_op;
      rsp_err    <= load_err;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: vector table for single commands plus hand-written
// backpressure, push/pop overlap, watchdog and mid-operation reset sequences.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  logic alu_hang = 1'b0;
  int   alu_lat  = 1;
  int   alu_cnt  = 0;

  logic [15:0] c_res [8];
  logic [2:0]  c_op  [8];
  logic        c_err [8];
  int          c_got;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int          lat;
    int          start;
  } vec_t;

  vec_t vecs [9];

  alu_cmd_issuer #(.DATA_W(8), .OP_W(3), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a} - {8'h00, b};
      3'd3:    return {8'h00, a} * {8'h00, b};
      3'd4:    return {8'h00, a & b};
      3'd5:    return {8'h00, a | b};
      3'd6:    return {8'h00, a ^ b};
      3'd7:    return {a, b};
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stand-in: done after alu_lat sampled cycles of start, never while hung.
  initial begin
    alu_done   = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_start && !alu_hang) begin
        if (alu_cnt >= alu_lat) begin
          alu_done   = 1'b1;
          alu_result = ref_alu(alu_opcode, alu_a, alu_b);
        end else begin
          alu_cnt++;
        end
      end else begin
        alu_done = 1'b0;
        alu_cnt  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int k;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    k = 0;
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      total++;
      bad++;
      $display("FAIL send_wait: got cmd_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    c_got = 0;
    for (int k = 0; k < 400 && c_got < n; k++) begin
      if (rsp_valid) begin
        c_res[c_got] = rsp_result;
        c_op[c_got]  = rsp_op;
        c_err[c_got] = rsp_err;
        c_got++;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          n, first_start;
    logic        got, opbad, e;
    logic [15:0] r;
    logic [2:0]  o;
    send(v.op, v.a, v.b);
    cmd_valid = 1'b0;
    got = 1'b0; opbad = 1'b0; first_start = 0; n = 0;
    r = '0; o = '0; e = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_start) begin
        if (first_start == 0) first_start = n;
        if (alu_a !== v.a || alu_b !== v.b || alu_opcode !== v.op) opbad = 1'b1;
      end
      if (rsp_valid) begin
        got = 1'b1;
        r = rsp_result;
        o = rsp_op;
        e = rsp_err;
      end
    end
    check({tag, "_got"}, got, 1);
    check({tag, "_res"}, r, v.res);
    check({tag, "_op"}, o, v.op);
    check({tag, "_err"}, e, 0);
    check({tag, "_lat"}, n, v.lat);
    check({tag, "_start"}, first_start, v.start);
    check({tag, "_operands"}, opbad, 0);
  endtask

  initial begin
    logic        flag;
    int          cnt;
    logic [15:0] exp_res [6];
    logic [2:0]  exp_op  [6];

    vecs[0] = '{3'd1, 8'h12, 8'h34, 16'h0046, 4, 2};
    vecs[1] = '{3'd3, 8'hFF, 8'hFF, 16'hFE01, 4, 2};
    vecs[2] = '{3'd0, 8'hAA, 8'h55, 16'h0000, 3, 0};
    vecs[3] = '{3'd2, 8'h10, 8'h20, 16'hFFF0, 4, 2};
    vecs[4] = '{3'd4, 8'hF0, 8'h3C, 16'h0030, 4, 2};
    vecs[5] = '{3'd5, 8'hF0, 8'h0F, 16'h00FF, 4, 2};
    vecs[6] = '{3'd6, 8'hAA, 8'hFF, 16'h0055, 4, 2};
    vecs[7] = '{3'd7, 8'hAB, 8'hCD, 16'hABCD, 4, 2};
    vecs[8] = '{3'd1, 8'hFF, 8'hFF, 16'h01FE, 4, 2};

    exp_res = '{16'h0046, 16'hFE01, 16'hFFF0, 16'h0000, 16'h0055, 16'h1234};
    exp_op  = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd6, 3'd7};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: five commands queue behind a stalled response.
    @(negedge clk);
    rsp_ready = 1'b0;
    send(3'd1, 8'h12, 8'h34);
    send(3'd3, 8'hFF, 8'hFF);
    send(3'd2, 8'h10, 8'h20);
    send(3'd0, 8'hAA, 8'h55);
    send(3'd6, 8'hAA, 8'hFF);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_count_full", fifo_count, 4);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_result", rsp_result, 16'h0046);
    check("bp_rsp_op", rsp_op, 1);
    repeat (5) @(negedge clk);
    check("bp_hold_valid", rsp_valid, 1);
    check("bp_hold_result", rsp_result, 16'h0046);
    rsp_ready = 1'b1;
    fork
      collect(6);
      begin
        send(3'd7, 8'h12, 8'h34);
        cmd_valid = 1'b0;
      end
    join
    check("bp_got", c_got, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_res%0d", i), c_res[i], exp_res[i]);
      check($sformatf("bp_op%0d", i), c_op[i], exp_op[i]);
    end
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) flag = 1'b1;
    end
    check("bp_no_extra", flag, 0);
    check("bp_count_empty", fifo_count, 0);

    // Push of a second command on the same edge the first is popped.
    send(3'd0, 8'h01, 8'h00);
    cmd_op = 3'd1; cmd_a = 8'h01; cmd_b = 8'h01;
    @(negedge clk);
    check("pp_count_a", fifo_count, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pp_count_b", fifo_count, 1);
    collect(2);
    check("pp_got", c_got, 2);
    check("pp_res0", c_res[0], 16'h0000);
    check("pp_op0", c_op[0], 0);
    check("pp_res1", c_res[1], 16'h0002);
    check("pp_op1", c_op[1], 1);
    check("pp_count_end", fifo_count, 0);

    // Watchdog: hung ALU, second command behind it.
    alu_hang = 1'b1;
    send(3'd1, 8'h01, 8'h02);
    send(3'd1, 8'h03, 8'h04);
    cmd_valid = 1'b0;
    cnt = 0;
    flag = 1'b0;
    for (int k = 0; k < 200 && !flag; k++) begin
      @(negedge clk);
      if (alu_start) cnt++;
      if (rsp_valid) flag = 1'b1;
    end
    check("to_got", flag, 1);
    check("to_start_cycles", cnt, 64);
    check("to_start_drop", alu_start, 0);
    check("to_err", rsp_err, 1);
    check("to_res", rsp_result, 0);
    check("to_op", rsp_op, 1);
    alu_hang = 1'b0;
    @(negedge clk);
    collect(1);
    check("to_next_got", c_got, 1);
    check("to_next_res", c_res[0], 16'h0007);
    check("to_next_err", c_err[0], 0);

    // Reset while waiting on the ALU with two commands queued.
    @(negedge clk);
    alu_hang = 1'b1;
    send(3'd1, 8'h05, 8'h05);
    send(3'd1, 8'h06, 8'h06);
    send(3'd1, 8'h07, 8'h07);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mr_count_pre", fifo_count, 2);
    check("mr_start_pre", alu_start, 1);
    rst_n = 1'b0;
    #1;
    check("mr_start", alu_start, 0);
    check("mr_count", fifo_count, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    alu_hang = 1'b0;
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || alu_start) flag = 1'b1;
    end
    check("mr_no_stale", flag, 0);
    run_vec(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
